// File: rtl/seq_det_controller.sv
// Runtime-programmable serial pattern detector with a config handshake, arm/run/done
// sequencing, overlapping or non-overlapping matching and a saturating match counter.
module seq_det_controller #(
   parameter int MAXLEN = 8,
   parameter int LENW   = 4,
   parameter int CNTW   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [MAXLEN-1:0] cfg_pattern,
   input  logic [LENW-1:0]   cfg_len,
   input  logic              cfg_overlap,
   input  logic [CNTW-1:0]   cfg_target,
   input  logic              start,
   input  logic              abort,
   input  logic              data,
   input  logic              data_valid,
   output logic              detected,
   output logic [CNTW-1:0]   match_count,
   output logic              busy,
   output logic              done
);

   // state | meaning
   // IDLE  | no valid config, waiting for cfg handshake
   // ARMED | config latched, waiting for start
   // RUN   | consuming qualified serial bits, detecting
   // DONE  | target count reached; start reruns, cfg reloads
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nx;
   logic [MAXLEN-1:0]   r_hist;
   logic [LENW-1:0]     r_fill;
   logic [MAXLEN-1:0]   r_pattern;
   logic [LENW-1:0]     r_len;
   logic                r_overlap;
   logic [CNTW-1:0]     r_target;
   logic [CNTW-1:0]     r_count;
   logic                r_detected;

   logic                w_hs;
   logic                w_start_go;
   logic                w_cfg_load;
   logic                w_shift;
   logic [MAXLEN-1:0]   w_hist_nx;
   logic [LENW-1:0]     w_fill_nx;
   logic [MAXLEN-1:0]   w_mask;
   logic                w_match;
   logic [CNTW-1:0]     w_cnt_inc;
   logic                w_hit_target;
   logic [LENW-1:0]     w_len_clamped;

   assign cfg_ready   = (r_state == S_IDLE) || (r_state == S_DONE);
   assign busy        = (r_state == S_RUN);
   assign done        = (r_state == S_DONE);
   assign detected    = r_detected;
   assign match_count = r_count;

   always_comb begin
      w_hs          = cfg_valid && cfg_ready;
      w_start_go    = !abort && start && ((r_state == S_ARMED) || (r_state == S_DONE));
      w_cfg_load    = !abort && !w_start_go && w_hs;
      w_shift       = (r_state == S_RUN) && data_valid && !abort;
      w_hist_nx     = {r_hist[MAXLEN-2:0], data};
      w_fill_nx     = (r_fill < r_len) ? r_fill + 1'b1 : r_fill;
      w_mask        = '0;
      for (int i = 0; i < MAXLEN; i++) begin
         w_mask[i] = (LENW'(i) < r_len);
      end
      // only the low len bits of the post-shift history take part in the compare
      w_match       = w_shift && (((w_hist_nx ^ r_pattern) & w_mask) == '0) && (w_fill_nx >= r_len);
      w_cnt_inc     = (r_count == {CNTW{1'b1}}) ? r_count : r_count + 1'b1;
      w_hit_target  = w_match && (r_target != '0) && (w_cnt_inc == r_target);
      w_len_clamped = cfg_len;
      if (cfg_len == '0) begin
         w_len_clamped = LENW'(1);
      end else if (cfg_len > LENW'(MAXLEN)) begin
         w_len_clamped = LENW'(MAXLEN);
      end
   end

   always_comb begin
      w_state_nx = r_state;
      if (abort) begin
         w_state_nx = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_hs) w_state_nx = S_ARMED;
            S_ARMED: if (start) w_state_nx = S_RUN;
            S_RUN:   if (w_hit_target) w_state_nx = S_DONE;
            S_DONE: begin
               if (start) w_state_nx = S_RUN;
               else if (w_hs) w_state_nx = S_ARMED;
            end
            default: w_state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hist     <= '0;
         r_fill     <= '0;
         r_pattern  <= '0;
         r_len      <= LENW'(1);
         r_overlap  <= 1'b0;
         r_target   <= '0;
         r_count    <= '0;
         r_detected <= 1'b0;
      end else begin
         r_detected <= w_match;
         if (w_start_go) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
         end else if (w_shift) begin
            r_hist <= w_hist_nx;
            // non-overlapping mode discards the matched bits so the next hit needs len fresh bits
            r_fill <= (w_match && !r_overlap) ? '0 : w_fill_nx;
            if (w_match) begin
               r_count <= w_cnt_inc;
            end
         end
         if (w_cfg_load) begin
            r_pattern <= cfg_pattern;
            r_len     <= w_len_clamped;
            r_overlap <= cfg_overlap;
            r_target  <= cfg_target;
         end
      end
   end

endmodule

// File: tb/tb_seq_det_controller.sv
// Directed bench for seq_det_controller: hand-computed pulse trains, counts and state flags.
module tb_seq_det_controller;

   logic       clk;
   logic       rst;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic [7:0] cfg_target;
   logic       start;
   logic       abort;
   logic       data;
   logic       data_valid;
   logic       detected;
   logic [7:0] match_count;
   logic       busy;
   logic       done;

   int n_vec;
   int n_err;
   logic [15:0] det_trace;
   int gap_pulses;

   seq_det_controller #(.MAXLEN(8), .LENW(4), .CNTW(8)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_target  (cfg_target),
      .start       (start),
      .abort       (abort),
      .data        (data),
      .data_valid  (data_valid),
      .detected    (detected),
      .match_count (match_count),
      .busy        (busy),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                         input logic ovl, input logic [7:0] tgt);
      cfg_valid   = 1'b1;
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      cfg_target  = tgt;
      tick();
      cfg_valid   = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      data       = b;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      det_trace  = {det_trace[14:0], detected};
   endtask

   task automatic send_stream(input logic [15:0] bits, input int n);
      det_trace = '0;
      for (int i = n - 1; i >= 0; i--) begin
         send_bit(bits[i]);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      gap_pulses = 0;
      det_trace = '0;
      rst = 1'b0;
      cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_target = '0;
      start = 1'b0; abort = 1'b0; data = 1'b0; data_valid = 1'b0;
      tick();
      chk("rst_detected", 32'(detected), 0);
      chk("rst_count", 32'(match_count), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_cfg_ready", 32'(cfg_ready), 1);
      rst = 1'b1;
      tick();

      // 1: 101 non-overlap
      do_cfg(8'b101, 4'd3, 1'b0, 8'd0);
      chk("armed_cfg_ready", 32'(cfg_ready), 0);
      chk("armed_busy", 32'(busy), 0);
      do_start();
      chk("run_busy", 32'(busy), 1);
      send_stream(16'b10101, 5);
      chk("t1_pulses", 32'(det_trace[4:0]), 32'b00100);
      chk("t1_count", 32'(match_count), 1);

      // 2: 101 overlap
      do_abort();
      do_cfg(8'b101, 4'd3, 1'b1, 8'd0);
      do_start();
      chk("t2_count_cleared", 32'(match_count), 0);
      send_stream(16'b10101, 5);
      chk("t2_pulses", 32'(det_trace[4:0]), 32'b00101);
      chk("t2_count", 32'(match_count), 2);

      // 3: 0110 target 2
      do_abort();
      do_cfg(8'b0110, 4'd4, 1'b0, 8'd2);
      do_start();
      send_stream(16'b011001101, 9);
      chk("t3_pulses", 32'(det_trace[8:0]), 32'b000100010);
      chk("t3_count", 32'(match_count), 2);
      chk("t3_done", 32'(done), 1);
      chk("t3_busy", 32'(busy), 0);
      chk("t3_cfg_ready", 32'(cfg_ready), 1);
      do_start();
      chk("t3_restart_busy", 32'(busy), 1);
      chk("t3_restart_done", 32'(done), 0);
      chk("t3_restart_count", 32'(match_count), 0);

      // 4: 101 with invalid gaps carrying toggling data
      do_abort();
      do_cfg(8'b101, 4'd3, 1'b0, 8'd0);
      do_start();
      det_trace = '0;
      begin
         logic [4:0] s;
         s = 5'b10101;
         for (int i = 4; i >= 0; i--) begin
            send_bit(s[i]);
            data = ~s[i];
            tick();
            if (detected) gap_pulses++;
            data = s[i];
            tick();
            if (detected) gap_pulses++;
         end
      end
      chk("t4_pulses", 32'(det_trace[4:0]), 32'b00100);
      chk("t4_gap_pulses", 32'(gap_pulses), 0);
      chk("t4_count", 32'(match_count), 1);

      // 5a: len 0 clamps to 1; cfg offer in RUN is ignored
      do_abort();
      do_cfg(8'h01, 4'd0, 1'b0, 8'd0);
      do_start();
      cfg_valid = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd1; cfg_target = 8'd1;
      #1;
      chk("t5_run_cfg_ready", 32'(cfg_ready), 0);
      tick();
      cfg_valid = 1'b0;
      chk("t5_run_still_busy", 32'(busy), 1);
      send_stream(16'b1011, 4);
      chk("t5_len0_pulses", 32'(det_trace[3:0]), 32'b1011);
      chk("t5_len0_count", 32'(match_count), 3);

      // 5b: len 12 clamps to 8
      do_abort();
      do_cfg(8'hA5, 4'd12, 1'b0, 8'd0);
      do_start();
      send_stream(16'hA5, 8);
      chk("t5_len12_pulses", 32'(det_trace[7:0]), 32'b00000001);
      chk("t5_len12_count", 32'(match_count), 1);

      // 6: abort beats start in RUN
      abort = 1'b1; start = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      chk("t6_abort_busy", 32'(busy), 0);
      chk("t6_abort_done", 32'(done), 0);
      chk("t6_abort_cfg_ready", 32'(cfg_ready), 1);
      chk("t6_abort_count_kept", 32'(match_count), 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t6_idle_start_ignored", 32'(busy), 0);

      // 6b: async reset mid-run with a pulse in flight
      do_cfg(8'b101, 4'd3, 1'b1, 8'd0);
      do_start();
      send_stream(16'b101, 3);
      chk("t6_pre_rst_detected", 32'(detected), 1);
      rst = 1'b0;
      #2;
      chk("t6_async_detected", 32'(detected), 0);
      chk("t6_async_count", 32'(match_count), 0);
      chk("t6_async_busy", 32'(busy), 0);
      chk("t6_async_done", 32'(done), 0);
      tick();
      rst = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
